// File: rtl/pulse_sequencer_if.sv
// Host-side control/status bundle for pulse_sequencer.
// Host drives start/stop/config; sequencer returns pin and status.
interface pulse_sequencer_if #(
  parameter int CW = 32,
  parameter int RW = 16
);
  logic          start;
  logic          stop;
  logic [CW-1:0] p1_width;
  logic [CW-1:0] delay;
  logic [CW-1:0] p2_width;
  logic [CW-1:0] period;
  logic [RW-1:0] nrep;
  logic          pulse_out;
  logic          sync_out;
  logic          busy;
  logic          done;
  logic [RW-1:0] rep_count;

  modport master (
    output start, stop,
    output p1_width, delay, p2_width,
    output period, nrep,
    input  pulse_out, sync_out,
    input  busy, done, rep_count
  );

  modport slave (
    input  start, stop,
    input  p1_width, delay, p2_width,
    input  period, nrep,
    output pulse_out, sync_out,
    output busy, done, rep_count
  );
endinterface

// File: rtl/pulse_sequencer.sv
// Two-pulse train generator with repeat count, start/stop, busy/done.
// Ports: clk, resetn (async low), bus (slave: config in, pin/status out).
module pulse_sequencer #(
  parameter int CW = 32,
  parameter int RW = 16
) (
  input logic               clk,
  input logic               resetn,
  pulse_sequencer_if.slave  bus
);

  // Phase math is done two bits wider so p1+d+p2 never wraps.
  localparam int SW = CW + 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] pc_q, pc_d;
  logic [SW-1:0] e1_q, e1_d;
  logic [SW-1:0] e2_q, e2_d;
  logic [SW-1:0] e3_q, e3_d;
  logic [SW-1:0] pe_q, pe_d;
  logic [RW-1:0] nrep_q, nrep_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          pulse_q, pulse_d;
  logic          sync_q, sync_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [SW-1:0] in_e1, in_e2, in_e3;
  logic [SW-1:0] in_per, in_pe;
  logic          emit;

  // Phase edges: pulse 1 ends at e1, pulse 2 spans [e2, e3).
  always_comb begin
    in_e1  = {2'b00, bus.p1_width};
    in_e2  = in_e1 + {2'b00, bus.delay};
    in_e3  = in_e2 + {2'b00, bus.p2_width};
    in_per = {2'b00, bus.period};
    in_pe  = (in_e3 > in_per) ? in_e3 : in_per;
    if (in_pe == '0) in_pe = SW'(1);
  end

  // Outputs are computed for the phase of the coming cycle,
  // so the registered pin is high in the cycle right after start.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    e3_d    = e3_q;
    pe_d    = pe_q;
    nrep_d  = nrep_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    emit    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = RUN;
          e1_d    = in_e1;
          e2_d    = in_e2;
          e3_d    = in_e3;
          pe_d    = in_pe;
          nrep_d  = bus.nrep;
          rep_d   = '0;
          pc_d    = '0;
          emit    = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
          pc_d    = '0;
        end else if (pc_q == pe_q - SW'(1)) begin
          rep_d = rep_q + RW'(1);
          pc_d  = '0;
          if (nrep_q != '0 && rep_d == nrep_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            emit = 1'b1;
          end
        end else begin
          pc_d = pc_q + SW'(1);
          emit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    pulse_d = emit &&
              ((pc_d < e1_d) ||
               (pc_d >= e2_d && pc_d < e3_d));
    sync_d  = emit && (pc_d == '0);
    busy_d  = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q    <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
      e3_q    <= '0;
      pe_q    <= '0;
      nrep_q  <= '0;
      rep_q   <= '0;
      pulse_q <= 1'b0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      e3_q    <= e3_d;
      pe_q    <= pe_d;
      nrep_q  <= nrep_d;
      rep_q   <= rep_d;
      pulse_q <= pulse_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.sync_out  = sync_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rep_count = rep_q;

endmodule
